// File: rtl/scope_pkg.sv
// scope_pkg: shared defaults and types for the acquisition path.
package scope_pkg;

    localparam int SCOPE_DEPTH   = 256;
    localparam int SCOPE_DW      = 12;
    localparam int SCOPE_PRETRIG = 32;

    // Capture sequencer states.
    typedef enum logic [2:0] {
        CAP_FILL   = 3'd0,
        CAP_ARMED  = 3'd1,
        CAP_POST   = 3'd2,
        CAP_UNLOAD = 3'd3,
        CAP_DONE   = 3'd4
    } cap_state_t;

    typedef logic [SCOPE_DW-1:0] sample_t;

endpackage

// File: rtl/trigger_capture_if.sv
// trigger_capture_if: ADC sample stream into the capture block (no back-pressure).
interface trigger_capture_if #(
    parameter int DW = scope_pkg::SCOPE_DW
);
    logic          sample_valid;
    logic [DW-1:0] sample_data;

    modport master (output sample_valid, sample_data);
    modport slave  (input  sample_valid, sample_data);
endinterface

// File: rtl/sample_ring.sv
// sample_ring: DEPTH x DW simple dual-port RAM, synchronous write,
// registered read with one cycle of latency. Contents are not reset.
module sample_ring #(
    parameter int DEPTH = 256,
    parameter int DW    = 12,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Storage write port plus registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/trigger_capture.sv
// trigger_capture: keeps the sample stream in a ring, finds a level/slope
// trigger, and builds a trigger-aligned frame with PRETRIG samples of
// history. The frame is copied to data_display only on a vblnk rise so
// the renderer never sees a half-updated trace.
// Optional feature: define TRIG_AUTO_EN to force a trigger after
// AUTO_TIMEOUT accepted samples in ARMED (free-running display).
// PRETRIG is expected to be at least 1.
module trigger_capture
    import scope_pkg::*;
#(
    parameter int DEPTH        = SCOPE_DEPTH,
    parameter int DW           = SCOPE_DW,
    parameter int PRETRIG      = SCOPE_PRETRIG,
    parameter int AUTO_TIMEOUT = 65535
) (
    input  logic                     clk,
    input  logic                     rst_n,
    trigger_capture_if.slave         s_in,
    input  logic [DW-1:0]            trig_level,
    input  logic                     trig_slope,
    input  logic                     vblnk,
    output logic [0:DEPTH-1][DW-1:0] data_display,
    output logic                     frame_ready,
    output logic                     busy
);
    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = AW + 1;
    localparam int POST_LEN = DEPTH - PRETRIG - 1;

    cap_state_t state_q, state_d;

    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             trig_ptr_q, trig_ptr_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [DW-1:0]             prev_q, prev_d;
    logic                      prev_valid_q, prev_valid_d;
    logic                      vblnk_q;
    logic [0:DEPTH-1][DW-1:0]  shadow_q, shadow_d;
    logic [0:DEPTH-1][DW-1:0]  display_q, display_d;
    logic                      frame_ready_q, frame_ready_d;

    logic          accept;
    logic [DW-1:0] cur;
    logic          rise_x, fall_x, crossing, auto_fire, trig_fire;
    logic          fill_last, post_last, unload_last, vblnk_rise;
    logic          rd_en;
    logic [AW-1:0] rd_addr, shadow_idx;
    logic [DW-1:0] rd_data;

    // Samples are taken only while the ring is being filled; UNLOAD/DONE drop them.
    assign accept = s_in.sample_valid &&
                    (state_q == CAP_FILL || state_q == CAP_ARMED || state_q == CAP_POST);
    assign cur    = s_in.sample_data;

    // Crossing needs a real previous sample; prev_valid is cleared on FILL entry.
    assign rise_x    = (prev_q < trig_level) && (cur >= trig_level);
    assign fall_x    = (prev_q > trig_level) && (cur <= trig_level);
    assign crossing  = prev_valid_q && (trig_slope ? fall_x : rise_x);
    assign trig_fire = (state_q == CAP_ARMED) && accept && (crossing || auto_fire);

    assign fill_last   = accept && (cnt_q == CW'(PRETRIG - 1));
    assign post_last   = accept && (cnt_q == CW'(POST_LEN - 1));
    assign unload_last = (cnt_q == CW'(DEPTH));
    assign vblnk_rise  = vblnk && !vblnk_q;

    // Unload walks the ring oldest-first from trig_ptr - PRETRIG; the
    // address wraps modulo DEPTH by width. Data returns one cycle later.
    assign rd_en      = (state_q == CAP_UNLOAD) && !unload_last;
    assign rd_addr    = trig_ptr_q - AW'(PRETRIG) + cnt_q[AW-1:0];
    assign shadow_idx = AW'(cnt_q - 1'b1);

`ifdef TRIG_AUTO_EN
    localparam int TW = $clog2(AUTO_TIMEOUT + 1);
    logic [TW-1:0] auto_cnt_q, auto_cnt_d;

    assign auto_fire = accept && (auto_cnt_q == TW'(AUTO_TIMEOUT - 1));

    // Count accepted samples in ARMED; held at zero elsewhere so each ARMED entry starts fresh.
    always_comb begin
        auto_cnt_d = auto_cnt_q;
        if (state_q != CAP_ARMED) begin
            auto_cnt_d = '0;
        end else if (accept) begin
            auto_cnt_d = auto_cnt_q + 1'b1;
        end
    end

    // Auto-trigger counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end
`else
    logic unused_auto;
    assign auto_fire   = 1'b0;
    assign unused_auto = (AUTO_TIMEOUT != 0);
`endif

    sample_ring #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_ring (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr_q),
        .wdata (cur),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CAP_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CAP_FILL:   if (fill_last)   state_d = CAP_ARMED;
            CAP_ARMED:  if (trig_fire)   state_d = (POST_LEN == 0) ? CAP_UNLOAD : CAP_POST;
            CAP_POST:   if (post_last)   state_d = CAP_UNLOAD;
            CAP_UNLOAD: if (unload_last) state_d = CAP_DONE;
            CAP_DONE:   if (vblnk_rise)  state_d = CAP_FILL;
            default:                     state_d = CAP_FILL;
        endcase
    end

    // Datapath next values: pointers, counters, shadow fill and frame publish.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        trig_ptr_d    = trig_ptr_q;
        cnt_d         = cnt_q;
        prev_d        = prev_q;
        prev_valid_d  = prev_valid_q;
        shadow_d      = shadow_q;
        display_d     = display_q;
        frame_ready_d = 1'b0;

        if (accept) begin
            wr_ptr_d     = wr_ptr_q + 1'b1;
            prev_d       = cur;
            prev_valid_d = 1'b1;
        end

        unique case (state_q)
            CAP_FILL: begin
                if (accept) cnt_d = fill_last ? '0 : cnt_q + 1'b1;
            end
            CAP_ARMED: begin
                if (trig_fire) begin
                    trig_ptr_d = wr_ptr_q;
                    cnt_d      = '0;
                end
            end
            CAP_POST: begin
                if (accept) cnt_d = post_last ? '0 : cnt_q + 1'b1;
            end
            CAP_UNLOAD: begin
                if (cnt_q != '0) shadow_d[shadow_idx] = rd_data;
                cnt_d = unload_last ? '0 : cnt_q + 1'b1;
            end
            CAP_DONE: begin
                if (vblnk_rise) begin
                    display_d     = shadow_q;
                    frame_ready_d = 1'b1;
                    prev_valid_d  = 1'b0;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Datapath registers; reset clears the published frame too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            trig_ptr_q    <= '0;
            cnt_q         <= '0;
            prev_q        <= '0;
            prev_valid_q  <= 1'b0;
            vblnk_q       <= 1'b0;
            shadow_q      <= '0;
            display_q     <= '0;
            frame_ready_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            trig_ptr_q    <= trig_ptr_d;
            cnt_q         <= cnt_d;
            prev_q        <= prev_d;
            prev_valid_q  <= prev_valid_d;
            vblnk_q       <= vblnk;
            shadow_q      <= shadow_d;
            display_q     <= display_d;
            frame_ready_q <= frame_ready_d;
        end
    end

    assign data_display = display_q;
    assign frame_ready  = frame_ready_q;
    assign busy         = (state_q != CAP_DONE);
endmodule

// File: tb/tb_trigger_capture.sv
// tb_trigger_capture: table-driven frame captures with a scoreboard of
// expected frames, plus hand sequences for reset-in-POST and constant input.
module tb_trigger_capture;
    import scope_pkg::*;

    localparam int DEPTH   = SCOPE_DEPTH;
    localparam int DW      = SCOPE_DW;
    localparam int PRETRIG = SCOPE_PRETRIG;
    localparam int AUTO_TO = 300;
    localparam int LIMIT   = 4000;

    typedef struct {
        string   name;
        int      start;
        int      step;
        sample_t level;
        bit      slope;
        bit      gap;
        bit      rst_before;
        bit      vb_high;
        bit      exp_frame;
        int      trig_idx;
        int      s_idx0;
        int      s_val0;
        int      s_idx1;
        int      s_val1;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    sample_t trig_level = '0;
    logic trig_slope = 1'b0;
    logic vblnk = 1'b0;
    logic [0:DEPTH-1][DW-1:0] data_display;
    logic [0:DEPTH-1][DW-1:0] disp_prev = '0;
    logic frame_ready, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int fr_cnt = 0;
    sample_t exp_q[$];
    vec_t vecs[9];

    trigger_capture_if #(.DW(DW)) s_if();

    trigger_capture #(
        .DEPTH(DEPTH), .DW(DW), .PRETRIG(PRETRIG), .AUTO_TIMEOUT(AUTO_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_in(s_if),
        .trig_level(trig_level), .trig_slope(trig_slope), .vblnk(vblnk),
        .data_display(data_display), .frame_ready(frame_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_ready === 1'b1) fr_cnt++;

    function automatic vec_t mk(string nm, int st, int sp, int lv, bit sl, bit gp,
                                bit rb, bit vh, bit ef, int ti,
                                int i0, int v0, int i1, int v1);
        vec_t v;
        v.name = nm; v.start = st; v.step = sp; v.level = sample_t'(lv); v.slope = sl;
        v.gap = gp; v.rst_before = rb; v.vb_high = vh; v.exp_frame = ef; v.trig_idx = ti;
        v.s_idx0 = i0; v.s_val0 = v0; v.s_idx1 = i1; v.s_val1 = v1;
        return v;
    endfunction

    function automatic sample_t stream_val(vec_t v, int n);
        int t;
        t = v.start + n * v.step;
        return sample_t'(t);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_display_zero"}, int'(data_display == '0), 1);
        chk({nm, "_frame_ready"}, int'(frame_ready), 0);
        chk({nm, "_busy"}, int'(busy), 1);
    endtask

    task automatic do_reset(input string nm);
        s_if.sample_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(nm);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        disp_prev = '0;
    endtask

    // Pop one expected frame from the scoreboard and compare it with data_display.
    task automatic check_frame(input string nm);
        int bad_idx;
        sample_t e, a, be, ba;
        bad_idx = -1; be = '0; ba = '0;
        n_cmp++;
        if (exp_q.size() < DEPTH) begin
            n_bad++;
            $display("FAIL %s_frame: got %0d queued entries expected %0d", nm, exp_q.size(), DEPTH);
            exp_q.delete();
            return;
        end
        for (int i = 0; i < DEPTH; i++) begin
            e = exp_q.pop_front();
            a = data_display[i];
            disp_prev[i] = e;
            if (a !== e && bad_idx < 0) begin
                bad_idx = i; be = e; ba = a;
            end
        end
        if (bad_idx >= 0) begin
            n_bad++;
            $display("FAIL %s_frame: index %0d got 0x%03h expected 0x%03h", nm, bad_idx, ba, be);
        end
    endtask

    task automatic run_vector(input vec_t v);
        int n, cyc, base;
        bit stable, done;
        if (v.rst_before) do_reset({v.name, "_rst"});
        trig_level = v.level;
        trig_slope = v.slope;
        vblnk = v.vb_high;
        if (v.exp_frame) begin
            for (int i = 0; i < DEPTH; i++) exp_q.push_back(stream_val(v, v.trig_idx - PRETRIG + i));
        end
        n = 0; cyc = 0; stable = 1'b1; done = 1'b0; base = fr_cnt;
        while (cyc < (v.exp_frame ? LIMIT : 1000)) begin
            s_if.sample_valid = !(v.gap && (cyc % 3 == 2));
            s_if.sample_data  = stream_val(v, n);
            @(posedge clk);
            #1;
            if (s_if.sample_valid) n++;
            cyc++;
            if (data_display !== disp_prev) stable = 1'b0;
            if (busy !== 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        s_if.sample_valid = 1'b0;
        chk({v.name, "_display_held"}, int'(stable), 1);
        if (!v.exp_frame) begin
            chk({v.name, "_never_done"}, int'(done), 0);
            chk({v.name, "_no_frame_ready"}, fr_cnt - base, 0);
            return;
        end
        chk({v.name, "_reached_done"}, int'(done), 1);
        if (!done) begin
            exp_q.delete();
            return;
        end
        if (v.vb_high) begin
            repeat (5) @(posedge clk);
            #1;
            chk({v.name, "_vblnk_high_no_update"}, fr_cnt - base, 0);
            chk({v.name, "_vblnk_high_display"}, int'(data_display === disp_prev), 1);
            vblnk = 1'b0;
            @(posedge clk);
            #1;
        end
        vblnk = 1'b1;
        @(posedge clk);
        #1;
        chk({v.name, "_frame_ready_pulse"}, int'(frame_ready), 1);
        check_frame(v.name);
        chk({v.name, "_spot_a"}, int'(data_display[v.s_idx0]), v.s_val0);
        chk({v.name, "_spot_b"}, int'(data_display[v.s_idx1]), v.s_val1);
        @(posedge clk);
        #1;
        chk({v.name, "_frame_ready_single"}, int'(frame_ready), 0);
        chk({v.name, "_busy_after"}, int'(busy), 1);
        vblnk = 1'b0;
    endtask

    initial begin
        vec_t fresh;
        int   trig_const;
        vecs[0] = mk("rise16",    0,     16,  'h400, 0, 0, 1, 0, 1, 64,  32, 'h400, 0,   'h200);
        vecs[1] = mk("fall16",    'hFF0, -16, 'h800, 1, 0, 0, 0, 1, 127, 32, 'h800, 255, 'hA10);
        vecs[2] = mk("wrap250",   28,    4,   'h400, 0, 1, 1, 0, 1, 249, 32, 'h400, 0,   'h380);
        vecs[3] = mk("ptr_wrap",  0,     2,   'h214, 0, 0, 1, 1, 1, 266, 32, 'h214, 0,   'h1D4);
        vecs[4] = mk("rise_geq",  0,     24,  'h401, 0, 0, 0, 0, 1, 43,  32, 'h408, 0,   'h108);
        vecs[5] = mk("fill_wins", 0,     17,  'h20F, 0, 0, 1, 0, 1, 272, 32, 'h210, 0,   'hFF0);
        vecs[6] = mk("fall_le",   'hFF0, -16, 'h7FF, 1, 1, 0, 0, 1, 128, 32, 'h7F0, 255, 'hA00);
        vecs[7] = mk("rise_rst",  0,     16,  'h400, 0, 0, 1, 0, 1, 64,  32, 'h400, 0,   'h200);
`ifdef TRIG_AUTO_EN
        trig_const = PRETRIG + AUTO_TO - 1;
        vecs[8] = mk("const_auto", 'h100, 0, 'h400, 0, 0, 1, 0, 1, trig_const, 32, 'h100, 255, 'h100);
`else
        trig_const = 0;
        vecs[8] = mk("const_norm", 'h100, 0, 'h400, 0, 0, 1, 0, 0, trig_const, 0, 0, 0, 0);
`endif
        s_if.sample_valid = 1'b0;
        s_if.sample_data  = '0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("power_on");
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++) run_vector(vecs[k]);

        // Abort a capture mid-POST: ramp triggers at sample 64, stop at 114.
        trig_level = 12'h400;
        trig_slope = 1'b0;
        if (vecs[8].exp_frame) begin
            for (int n = 0; n < 114; n++) begin
                s_if.sample_valid = 1'b1;
                s_if.sample_data  = sample_t'(n * 16);
                @(posedge clk);
                #1;
            end
        end else begin
            do_reset("pre_post_abort");
            run_vector(vecs[0]);
            for (int n = 0; n < 114; n++) begin
                s_if.sample_valid = 1'b1;
                s_if.sample_data  = sample_t'(n * 16);
                @(posedge clk);
                #1;
            end
        end
        chk("post_abort_prior_frame_nonzero", int'(data_display != '0), 1);
        do_reset("post_abort");

        // After the abort the crossing inside FILL is ignored; first trigger is at sample 272.
        fresh = mk("fresh_cross", 'h300, 16, 'h400, 0, 0, 0, 0, 1, 272, 32, 'h400, 0, 'h200);
        run_vector(fresh);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end
endmodule
